// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 receiver, LSB first, fixed bit period, 2-flop input synchroniser and a
// one-entry valid/ready holding register; framing errors and overruns are 1-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sh, sh_nx, data_nx;
  logic          valid_nx, ferr_nx, ovr_nx, commit;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rxd_i};

  assign rxs = sync[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    commit   = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      WAIT_HIGH: if (rxs) state_nx = IDLE;
      IDLE: if (!rxs) begin
        state_nx = START;
        cnt_nx   = '0;
      end
      START: if (cnt == HALF) begin
        if (rxs) state_nx = IDLE;
        else begin
          state_nx = DATA;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end else cnt_nx = cnt + 1'b1;
      DATA: if (cnt == LAST) begin
        sh_nx  = {rxs, sh[7:1]};
        cnt_nx = '0;
        idx_nx = idx + 1'b1;
        if (idx == 3'd7) state_nx = STOP;
      end else cnt_nx = cnt + 1'b1;
      STOP: if (cnt == LAST) begin
        // Returning to IDLE at mid-stop leaves half a bit of margin for the next start.
        if (rxs) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else begin
          ferr_nx  = 1'b1;
          state_nx = WAIT_HIGH;
        end
      end else cnt_nx = cnt + 1'b1;
      default: state_nx = WAIT_HIGH;
    endcase
  end

  // Holding register: a commit may land on the same edge the old byte drains.
  always_comb begin
    data_nx  = rx_data_o;
    valid_nx = rx_valid_o;
    ovr_nx   = 1'b0;
    if (commit) begin
      if (!rx_valid_o || rx_ready_i) begin
        data_nx  = sh;
        valid_nx = 1'b1;
      end else ovr_nx = 1'b1;
    end else if (rx_valid_o && rx_ready_i) valid_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= WAIT_HIGH;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      sh          <= sh_nx;
      rx_data_o   <= data_nx;
      rx_valid_o  <= valid_nx;
      frame_err_o <= ferr_nx;
      overrun_o   <= ovr_nx;
    end
endmodule
